// File: rtl/memory_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : memory_bank_if
//  Purpose  : Bus bundle between a requester (switch/button logic) and the
//             memory_bank storage block.
//  Signals  : data     - write data (WIDTH)
//             store    - write strobe
//             addr     - word address for store and load (ADDR_W)
//             load     - read request
//             clear    - start sequential clear of all words
//             memory   - registered read data (WIDTH)
//             rd_valid - one-cycle pulse when memory was updated by a load
//             hit      - addressed word had been written since clear/reset
//             busy     - clear engine running
//             valid    - per-word written flags (DEPTH)
//  Modports : master (requester side), slave (memory_bank side)
//  Revision : 1.0 - initial release
// ============================================================================
interface memory_bank_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  data;
  logic              store;
  logic [ADDR_W-1:0] addr;
  logic              load;
  logic              clear;
  logic [WIDTH-1:0]  memory;
  logic              rd_valid;
  logic              hit;
  logic              busy;
  logic [DEPTH-1:0]  valid;

  modport master (
    output data, store, addr, load, clear,
    input  memory, rd_valid, hit, busy, valid
  );

  modport slave (
    input  data, store, addr, load, clear,
    output memory, rd_valid, hit, busy, valid
  );
endinterface
`default_nettype wire

// File: rtl/memory_bank.sv
`default_nettype none
// ============================================================================
//  Module   : memory_bank
//  Purpose  : DEPTH x WIDTH register-array memory with synchronous write,
//             registered read port, per-word valid flags and a sequential
//             clear engine that zeroes one word per clock.
//  Ports    : clk   - rising-edge clock
//             reset - asynchronous active-high reset
//             bus   - memory_bank_if.slave (data/store/addr/load/clear in,
//                     memory/rd_valid/hit/busy/valid out)
//  Revision : 1.0 - initial release
// ============================================================================
module memory_bank #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  memory_bank_if.slave  bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] c_last_ptr = ADDR_W'(DEPTH - 1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_ptr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [DEPTH-1:0]  r_valid;
  logic [WIDTH-1:0]  r_memory;
  logic              r_hit;
  logic              r_rd_valid;

  logic              w_start_clear;
  logic              w_clear_last;
  logic              w_in_range;
  logic              w_write;
  logic              w_read;
  logic [WIDTH-1:0]  w_rd_data;
  logic              w_rd_hit;

  // Next-state logic and request qualification. A clear request on an IDLE
  // edge wins over any store/load presented on the same edge.
  always_comb begin
    w_state_next  = r_state;
    w_start_clear = 1'b0;
    w_clear_last  = (r_ptr == c_last_ptr);
    w_in_range    = (int'(bus.addr) < DEPTH);
    w_write       = 1'b0;
    w_read        = 1'b0;

    case (r_state)
      IDLE: begin
        if (bus.clear) begin
          w_state_next  = CLEAR;
          w_start_clear = 1'b1;
        end else begin
          w_write = bus.store && w_in_range;
          w_read  = bus.load;
        end
      end
      CLEAR: begin
        if (w_clear_last) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Read mux: write-first on a same-cycle store, zero for out-of-range.
  always_comb begin
    w_rd_data = '0;
    w_rd_hit  = 1'b0;
    if (w_write) begin
      w_rd_data = bus.data;
      w_rd_hit  = 1'b1;
    end else if (w_in_range) begin
      w_rd_data = r_mem[bus.addr];
      w_rd_hit  = r_valid[bus.addr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_valid    <= '0;
      r_memory   <= '0;
      r_hit      <= 1'b0;
      r_rd_valid <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      r_state    <= w_state_next;
      r_rd_valid <= w_read;

      if (w_start_clear) begin
        r_ptr <= '0;
      end else if (r_state == CLEAR) begin
        r_mem[r_ptr]   <= '0;
        r_valid[r_ptr] <= 1'b0;
        // Explicit return to 0 so non-power-of-two depths never step past
        // the last word.
        r_ptr <= w_clear_last ? '0 : r_ptr + ADDR_W'(1);
      end

      if (w_write) begin
        r_mem[bus.addr]   <= bus.data;
        r_valid[bus.addr] <= 1'b1;
      end

      if (w_read) begin
        r_memory <= w_rd_data;
        r_hit    <= w_rd_hit;
      end
    end
  end

  assign bus.memory   = r_memory;
  assign bus.hit      = r_hit;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = (r_state == CLEAR);
  assign bus.valid    = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_memory_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_memory_bank
//  Purpose  : Directed self-checking bench for memory_bank. Instance a is the
//             default 4x8 memory, instance b a 5x12 memory exercising the
//             non-power-of-two depth and out-of-range addresses.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_memory_bank;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  memory_bank_if #(.WIDTH(8),  .DEPTH(4)) bus_a ();
  memory_bank_if #(.WIDTH(12), .DEPTH(5)) bus_b ();

  memory_bank #(.WIDTH(8), .DEPTH(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  memory_bank #(.WIDTH(12), .DEPTH(5)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    bus_a.data = '0; bus_a.store = 0; bus_a.addr = '0; bus_a.load = 0; bus_a.clear = 0;
    bus_b.data = '0; bus_b.store = 0; bus_b.addr = '0; bus_b.load = 0; bus_b.clear = 0;
    tick();
    tick();

    check("rst_memory",   32'(bus_a.memory),   32'h0);
    check("rst_hit",      32'(bus_a.hit),      32'h0);
    check("rst_rd_valid", 32'(bus_a.rd_valid), 32'h0);
    check("rst_busy",     32'(bus_a.busy),     32'h0);
    check("rst_valid",    32'(bus_a.valid),    32'h0);
    reset = 1'b0;

    // Load of an unwritten word
    bus_a.load = 1; bus_a.addr = 2'd2;
    tick();
    bus_a.load = 0;
    check("ld2_memory",   32'(bus_a.memory),   32'h00);
    check("ld2_hit",      32'(bus_a.hit),      32'h0);
    check("ld2_rd_valid", 32'(bus_a.rd_valid), 32'h1);
    check("ld2_valid",    32'(bus_a.valid),    32'b0000);
    tick();
    check("rd_valid_pulse", 32'(bus_a.rd_valid), 32'h0);

    // Stores then loads
    bus_a.store = 1; bus_a.addr = 2'd0; bus_a.data = 8'hA5;
    tick();
    bus_a.addr = 2'd3; bus_a.data = 8'h3C;
    tick();
    bus_a.store = 0; bus_a.load = 1; bus_a.addr = 2'd3;
    tick();
    check("ld3_memory", 32'(bus_a.memory), 32'h3C);
    check("ld3_hit",    32'(bus_a.hit),    32'h1);
    check("ld3_valid",  32'(bus_a.valid),  32'b1001);
    bus_a.addr = 2'd1;
    tick();
    bus_a.load = 0;
    check("ld1_memory", 32'(bus_a.memory), 32'h00);
    check("ld1_hit",    32'(bus_a.hit),    32'h0);
    tick();
    check("hold_memory", 32'(bus_a.memory), 32'h00);

    // Write-first store+load on the same edge
    bus_a.store = 1; bus_a.load = 1; bus_a.addr = 2'd1; bus_a.data = 8'h77;
    tick();
    bus_a.load = 0;
    check("wf_memory",   32'(bus_a.memory),   32'h77);
    check("wf_hit",      32'(bus_a.hit),      32'h1);
    check("wf_rd_valid", 32'(bus_a.rd_valid), 32'h1);
    bus_a.addr = 2'd2; bus_a.data = 8'h22;
    tick();
    bus_a.store = 0;
    check("full_valid", 32'(bus_a.valid), 32'b1111);

    // Sequential clear; store/load/clear during busy must be dropped
    bus_a.clear = 1;
    tick();
    check("clr0_busy",  32'(bus_a.busy),  32'h1);
    check("clr0_valid", 32'(bus_a.valid), 32'b1111);
    bus_a.store = 1; bus_a.addr = 2'd2; bus_a.data = 8'hFF; bus_a.load = 1;
    tick();
    bus_a.store = 0; bus_a.load = 0; bus_a.clear = 0;
    check("clr1_busy",     32'(bus_a.busy),     32'h1);
    check("clr1_valid",    32'(bus_a.valid),    32'b1110);
    check("clr1_rd_valid", 32'(bus_a.rd_valid), 32'h0);
    check("clr1_memory",   32'(bus_a.memory),   32'h77);
    tick();
    check("clr2_busy",  32'(bus_a.busy),  32'h1);
    check("clr2_valid", 32'(bus_a.valid), 32'b1100);
    tick();
    check("clr3_busy",  32'(bus_a.busy),  32'h1);
    check("clr3_valid", 32'(bus_a.valid), 32'b1000);
    tick();
    check("clr4_busy",  32'(bus_a.busy),  32'h0);
    check("clr4_valid", 32'(bus_a.valid), 32'b0000);
    tick();
    check("clr_norestart", 32'(bus_a.busy), 32'h0);
    bus_a.load = 1; bus_a.addr = 2'd2;
    tick();
    bus_a.load = 0;
    check("postclr_memory",   32'(bus_a.memory),   32'h00);
    check("postclr_hit",      32'(bus_a.hit),      32'h0);
    check("postclr_rd_valid", 32'(bus_a.rd_valid), 32'h1);

    // Clear priority over store, then async reset in the 2nd clear cycle
    bus_a.store = 1; bus_a.addr = 2'd3; bus_a.data = 8'h99;
    tick();
    bus_a.store = 0; bus_a.load = 1;
    tick();
    bus_a.load = 0;
    check("pre_abort_memory", 32'(bus_a.memory), 32'h99);
    bus_a.clear = 1; bus_a.store = 1; bus_a.addr = 2'd0; bus_a.data = 8'h55;
    tick();
    bus_a.clear = 0; bus_a.store = 0;
    check("prio_busy",  32'(bus_a.busy),  32'h1);
    check("prio_valid", 32'(bus_a.valid), 32'b1000);
    tick();
    check("abort_pre_busy", 32'(bus_a.busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("abort_busy",   32'(bus_a.busy),   32'h0);
    check("abort_valid",  32'(bus_a.valid),  32'b0000);
    check("abort_memory", 32'(bus_a.memory), 32'h00);
    #1 reset = 1'b0;
    tick();
    bus_a.store = 1; bus_a.addr = 2'd1; bus_a.data = 8'h11;
    tick();
    bus_a.store = 0;
    check("after_abort_valid", 32'(bus_a.valid), 32'b0010);
    check("after_abort_busy",  32'(bus_a.busy),  32'h0);
    tick();
    check("no_restart_busy", 32'(bus_a.busy), 32'h0);

    // DEPTH=5, WIDTH=12
    bus_b.store = 1; bus_b.addr = 3'd4; bus_b.data = 12'hABC;
    tick();
    bus_b.store = 0; bus_b.load = 1;
    tick();
    bus_b.load = 0;
    check("b_ld4_memory", 32'(bus_b.memory), 32'hABC);
    check("b_ld4_hit",    32'(bus_b.hit),    32'h1);
    bus_b.store = 1; bus_b.addr = 3'd6; bus_b.data = 12'h123;
    tick();
    bus_b.store = 0; bus_b.load = 1;
    tick();
    bus_b.load = 0;
    check("b_oor_memory",   32'(bus_b.memory),   32'h000);
    check("b_oor_hit",      32'(bus_b.hit),      32'h0);
    check("b_oor_rd_valid", 32'(bus_b.rd_valid), 32'h1);
    check("b_valid",        32'(bus_b.valid),    32'b10000);

    // Clear of a 5-deep memory must run exactly five cycles
    bus_b.clear = 1;
    tick();
    bus_b.clear = 0;
    n = 0;
    for (int i = 0; i < 20 && bus_b.busy; i++) begin
      n++;
      tick();
    end
    check("b_busy_cycles", 32'(n), 32'd5);
    check("b_clr_valid",   32'(bus_b.valid), 32'b00000);
    check("b_clr_busy",    32'(bus_b.busy),  32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
